vga_anim_sequencer: RTL



---
 rtl/vga_pkg.sv | 69 ++++++
 rtl/vga_btn_debounce.sv | 64 ++++++
 rtl/vga_anim_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA animation path: sequencer states, 640x480
// timing, default bounce box and a helper for one axis of bounce motion.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STEP_X,
    STEP_Y,
    SCENE,
    COMMIT
  } anim_state_e;

  // 640x480 @ 60 Hz timing, pixel clock 25.175 MHz
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Default bounce box
  localparam logic [8:0] DEF_X_MIN  = 9'd10;
  localparam logic [8:0] DEF_X_MAX  = 9'd280;
  localparam logic [8:0] DEF_Y_MIN  = 9'd10;
  localparam logic [8:0] DEF_Y_MAX  = 9'd420;
  localparam logic [8:0] DEF_X_INIT = 9'd100;
  localparam logic [8:0] DEF_Y_INIT = 9'd100;

  localparam int NUM_SCENES = 4;

  // Position along one axis plus direction (0 = increasing, 1 = decreasing)
  typedef struct packed {
    logic [8:0] pos;
    logic       dir;
  } axis_t;

  // One bounce step. 10-bit intermediates keep the comparisons free of
  // wrap-around so the result always lands inside [lo, hi].
  function automatic axis_t bounce_step(axis_t cur, logic [2:0] s,
                                        logic [8:0] lo, logic [8:0] hi);
    axis_t      r;
    logic [9:0] sum;
    logic [9:0] lim;
    r   = cur;
    sum = {1'b0, cur.pos} + {7'd0, s};
    lim = {1'b0, lo} + {7'd0, s};
    if (!cur.dir) begin
      if (sum >= {1'b0, hi}) begin
        r.pos = hi;
        r.dir = 1'b1;
      end else begin
        r.pos = sum[8:0];
      end
    end else begin
      if ({1'b0, cur.pos} <= lim) begin
        r.pos = lo;
        r.dir = 1'b0;
      end else begin
        r.pos = cur.pos - {6'd0, s};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, a stable counter that only
// advances on frame ticks, and a single-cycle press pulse per press.
module vga_btn_debounce
  import vga_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic tick,
  output logic press
);

  localparam logic [2:0] DEB    = 3'(DEB_FRAMES);
  localparam logic [2:0] DEB_M1 = 3'(DEB_FRAMES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       level_q, level_d;
  logic [2:0] cnt_q, cnt_d;
  logic       press_q, press_d;

  // Stability tracking; the press fires on the tick where a high level
  // first reaches the full count, so a long hold still yields one event.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (tick) begin
      if (sync2_q == level_q) begin
        if (cnt_q != DEB) begin
          cnt_d = cnt_q + 3'd1;
          if (level_q && (cnt_q == DEB_M1)) press_d = 1'b1;
        end
      end else begin
        cnt_d   = 3'd0;
        level_d = sync2_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 3'd0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/vga_anim_sequencer.sv
// Frame-synchronous animation sequencer: steps a bouncing object once per
// frame on a short FSM and commits all outputs together in vertical blanking.
module vga_anim_sequencer
  import vga_pkg::*;
#(
  parameter logic [8:0]  X_MIN      = DEF_X_MIN,
  parameter logic [8:0]  X_MAX      = DEF_X_MAX,
  parameter logic [8:0]  Y_MIN      = DEF_Y_MIN,
  parameter logic [8:0]  Y_MAX      = DEF_Y_MAX,
  parameter logic [8:0]  X_INIT     = DEF_X_INIT,
  parameter logic [8:0]  Y_INIT     = DEF_Y_INIT,
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        btn_pause,
  input  logic        btn_next,
  input  logic [1:0]  spd,
  output logic [8:0]  obj_x,
  output logic [8:0]  obj_y,
  output logic [1:0]  scene,
  output logic [15:0] frame_cnt,
  output logic        paused,
  output logic        cfg_valid
);

  anim_state_e state_q, state_d;
  logic        vsync_prev_q;
  logic        tick;
  logic        next_evt, pause_evt;

  // Working copy, only visible to the pixel path after COMMIT
  axis_t       wx_q, wx_d, wy_q, wy_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  wscene_q, wscene_d;
  logic [15:0] wfc_q, wfc_d;
  logic        wpaused_q, wpaused_d;
  logic        pend_next_q, pend_next_d;
  logic        pend_pause_q, pend_pause_d;

  // Committed outputs
  logic [8:0]  obj_x_q, obj_x_d, obj_y_q, obj_y_d;
  logic [1:0]  scene_q, scene_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        paused_q, paused_d;
  logic        cfg_valid_q, cfg_valid_d;

  // Rising vsync marks the end of the sync pulse, still inside vblank
  assign tick = vsync & ~vsync_prev_q;

  vga_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_pause (
    .clk(clk), .rst_n(rst_n), .btn(btn_pause), .tick(tick), .press(pause_evt)
  );

  vga_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_next (
    .clk(clk), .rst_n(rst_n), .btn(btn_next), .tick(tick), .press(next_evt)
  );

  // Next-state and datapath: one FSM state per cycle, output copy in COMMIT
  always_comb begin
    state_d      = state_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    step_d       = step_q;
    wscene_d     = wscene_q;
    wfc_d        = wfc_q;
    wpaused_d    = wpaused_q;
    // Press pulses arrive just after the tick; hold them until SCENE
    pend_next_d  = pend_next_q | next_evt;
    pend_pause_d = pend_pause_q | pause_evt;
    obj_x_d      = obj_x_q;
    obj_y_d      = obj_y_q;
    scene_d      = scene_q;
    frame_cnt_d  = frame_cnt_q;
    paused_d     = paused_q;
    cfg_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) state_d = STEP_X;
      end
      STEP_X: begin
        step_d = {1'b0, spd} + 3'd1;
        if (!wpaused_q) wx_d = bounce_step(wx_q, step_d, X_MIN, X_MAX);
        state_d = STEP_Y;
      end
      STEP_Y: begin
        if (!wpaused_q) wy_d = bounce_step(wy_q, step_q, Y_MIN, Y_MAX);
        state_d = SCENE;
      end
      SCENE: begin
        if (pend_next_q)
          wscene_d = (wscene_q == 2'(NUM_SCENES - 1)) ? 2'd0 : wscene_q + 2'd1;
        // Counter uses the pause state of this frame; a toggle lands next frame
        if (!wpaused_q) wfc_d = wfc_q + 16'd1;
        if (pend_pause_q) wpaused_d = ~wpaused_q;
        pend_next_d  = next_evt;
        pend_pause_d = pause_evt;
        state_d      = COMMIT;
      end
      COMMIT: begin
        obj_x_d     = wx_q.pos;
        obj_y_d     = wy_q.pos;
        scene_d     = wscene_q;
        frame_cnt_d = wfc_q;
        paused_d    = wpaused_q;
        cfg_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset returns every flop to its power-up value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vsync_prev_q <= 1'b0;
      wx_q         <= '{pos: X_INIT, dir: 1'b0};
      wy_q         <= '{pos: Y_INIT, dir: 1'b0};
      step_q       <= 3'd1;
      wscene_q     <= 2'd0;
      wfc_q        <= 16'd0;
      wpaused_q    <= 1'b0;
      pend_next_q  <= 1'b0;
      pend_pause_q <= 1'b0;
      obj_x_q      <= X_INIT;
      obj_y_q      <= Y_INIT;
      scene_q      <= 2'd0;
      frame_cnt_q  <= 16'd0;
      paused_q     <= 1'b0;
      cfg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vsync;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      step_q       <= step_d;
      wscene_q     <= wscene_d;
      wfc_q        <= wfc_d;
      wpaused_q    <= wpaused_d;
      pend_next_q  <= pend_next_d;
      pend_pause_q <= pend_pause_d;
      obj_x_q      <= obj_x_d;
      obj_y_q      <= obj_y_d;
      scene_q      <= scene_d;
      frame_cnt_q  <= frame_cnt_d;
      paused_q     <= paused_d;
      cfg_valid_q  <= cfg_valid_d;
    end
  end

  assign obj_x     = obj_x_q;
  assign obj_y     = obj_y_q;
  assign scene     = scene_q;
  assign frame_cnt = frame_cnt_q;
  assign paused    = paused_q;
  assign cfg_valid = cfg_valid_q;

endmodule
